// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a 2-entry instruction queue.
// A small FSM (IDLE/WAIT/DROP) issues at most one instruction memory request
// at a time. It latches the fetch address from the program counter and pulses
// pc_en_o so the PC advances. Returned words are pushed with their address
// into a circular FIFO that feeds decode through a valid/ready handshake.
// A flush discards queued entries. It also discards the in-flight response.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   pc_i         current fetch address from the PC register
//   pc_en_o      one-cycle pulse telling the PC to load its next value
//   imem_req_o   memory request, held until acknowledged
//   imem_addr_o  request address (the latched fetch address)
//   imem_ack_i   one-cycle memory acknowledge
//   imem_data_i  instruction word, valid with imem_ack_i
//   flush_i      redirect: drop queued and in-flight instructions
//   valid_o      queue head holds an instruction
//   ready_i      decode accepts the head this cycle
//   inst_o       head instruction word
//   pc_o         head instruction address
//   pc_plus4_o   pc_o + 4 (wraps modulo 2^32)
module fetch_queue (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] req_pc;
  logic [31:0] entry_inst [2];
  logic [31:0] entry_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        room;
  logic        issue;
  logic        push;
  logic        pop;
  logic        req;

  // The room check uses the registered count only. A pop in the same cycle
  // does not free a slot until the next cycle, so the queue cannot overflow.
  assign room = (count != 2'd2);
  assign pop  = valid_o && ready_i;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (room && !flush_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          state_next = IDLE;
        end else if (flush_i) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    req   = 1'b0;
    case (state)
      IDLE: issue = room && !flush_i;
      WAIT: begin
        req  = 1'b1;
        push = imem_ack_i && !flush_i;
      end
      DROP: req = 1'b1;
      default: begin
        issue = 1'b0;
        push  = 1'b0;
        req   = 1'b0;
      end
    endcase
    // Reset blocks any new request and any push, whatever the FSM state is
    // during the reset cycle.
    if (rst_i) begin
      issue = 1'b0;
      push  = 1'b0;
      req   = 1'b0;
    end
  end

  assign pc_en_o     = issue;
  assign imem_req_o  = req;
  assign imem_addr_o = req_pc;

  // Fetch address latch; it stays stable for the whole request (WAIT/DROP).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc <= '0;
    end else if (issue) begin
      req_pc <= pc_i;
    end
  end

  // ---------------------------------------------------------------------
  // Instruction queue: 2-entry circular FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) begin
        entry_inst[i] <= '0;
        entry_pc[i]   <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush_i) begin
      // Flush overrides any pop in the same cycle. Push is already blocked
      // while flush_i is high. Stale entries stay in place but become invisible.
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        entry_inst[wr_ptr] <= imem_data_i;
        entry_pc[wr_ptr]   <= req_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid_o    = (count != 2'd0);
  assign inst_o     = entry_inst[rd_ptr];
  assign pc_o       = entry_pc[rd_ptr];
  assign pc_plus4_o = pc_o + 32'd4;

endmodule
